signed_div_seq: RTL and testbench
=================================

SIGNED_DIV_SEQ -- requirements
Module: signed_div_seq

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only while idle.
REQ-004 signed_en  input  1  1 = operands and results are two's complement; 0 = unsigned.
REQ-005 dividend  input  32  numerator, captured on the accepted start edge.
REQ-006 divisor  input  32  denominator, captured on the accepted start edge.
REQ-007 quotient  output  32  registered result; holds until the next accepted start.
REQ-008 remainder  output  32  registered result; sign follows the dividend.
REQ-009 exception  output  1  divide-by-zero flag, valid while ready is high and held afterwards.
REQ-010 busy  output  1  high from the accepted-start edge until the edge on which ready rises.
REQ-011 ready  output  1  one-cycle pulse that marks quotient, remainder and exception valid.

Function
REQ-012 States: IDLE, RUN, FIX, DONE.
  - IDLE->RUN on start.
  - RUN->FIX after 32 iterations.
  - FIX->DONE.
  - DONE->IDLE.
REQ-013 Accepted start edge (edge 0):
  - capture magnitudes: the operand is negated when signed_en & bit31, otherwise passed through.
  - capture qneg = signed_en & (dividend[31] ^ divisor[31]).
  - capture rneg = signed_en & dividend[31].
  - capture dz = (divisor == 0).
REQ-014 RUN: one restoring shift-subtract iteration per cycle on a 33-bit partial remainder; iteration counter is 6 bits and counts 0..31.
REQ-015 FIX:
  - negate the unsigned quotient when qneg, and the unsigned remainder when rneg.
  - when dz, force quotient = 0, remainder = 0, exception = 1.
  - otherwise exception = 0.
REQ-016 Latency:
  - ready is high for exactly one cycle following the 34th rising edge after the start edge.
  - latency is the same for every operand value, including dz.
REQ-017 start while busy is ignored; captured operands are not disturbed.
REQ-018 start arriving in the DONE cycle is ignored; start in IDLE on the cycle after ready is accepted.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, exception 0 (wraps, no flag).
REQ-020 Input changes after the start edge have no effect on the result.
REQ-021 Magnitude 0x80000000 is treated as unsigned 2^31 internally; no overflow is lost.

Reset
REQ-022 reset_n low asynchronously forces:
  - state IDLE;
  - quotient, remainder and counter to 0;
  - exception, busy and ready to 0.
REQ-023 Reset mid-RUN or mid-FIX aborts the operation; ready is not asserted for it, and the block accepts start on the first edge after reset_n rises.

Structure
REQ-024 A shared package holds:
  - WIDTH = 32 and ITER = 32;
  - the state enum {IDLE, RUN, FIX, DONE};
  - the counter width.
REQ-025 One sub-module, cond_negate (32-bit: output = enable ? two's-complement negation of input : input), is instantiated four times: two operands and two results.
REQ-026 No combinational path from any input to any output.

Verification
REQ-027 Unsigned 100/7, signed_en = 0 -> edge 34: ready = 1, quotient = 14, remainder = 2, exception = 0.
REQ-028 Signed -100/7 (0xFFFFFF9C / 7) -> quotient = 0xFFFFFFF2, remainder = 0xFFFFFFFE; signed 100/-7 -> quotient = 0xFFFFFFF2, remainder = 2.
REQ-029 Divide by zero, 55/0 -> ready at edge 34, exception = 1, quotient = 0, remainder = 0; a following 9/3 gives quotient = 3, exception = 0.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0, exception = 0; the same operands unsigned -> quotient = 0, remainder = 0x80000000.
REQ-031 Start 100/7, second start 9/3 at edge 5 -> single ready at edge 34 with quotient = 14; busy is continuous edges 0..34.
REQ-032 Start 100/7, reset_n low at edge 10 -> all outputs 0 immediately, no ready; a new start 20/6 after release -> quotient = 3, remainder = 2, 34 edges later.

Source files
------------

// File: rtl/signed_div_seq_pkg.sv
// Shared definitions for the sequential signed/unsigned divider.
//   WIDTH    : operand and result width
//   ITER     : shift-subtract iterations per divide
//   CNT_W    : iteration counter width
//   CNT_LAST : counter value of the final iteration
//   state_t  : controller states
package signed_div_seq_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation.
//   i_en  : 1 = output the negation of i_val, 0 = pass i_val through
//   i_val : input value
//   o_val : result
module cond_negate
   import signed_div_seq_pkg::*;
(
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_en ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/signed_div_seq.sv
// Sequential 32-bit divider, restoring shift-subtract, one iteration per clock.
// Operands are reduced to magnitudes on the accepted start edge; signs are
// reapplied in FIX. Results appear together with a one-cycle ready pulse
// 34 edges after the start edge, independent of operand values.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   signed_en : 1 = two's-complement operands/results, 0 = unsigned
//   dividend  : numerator, captured on the accepted start edge
//   divisor   : denominator, captured on the accepted start edge
//   quotient  : registered quotient, held until the next result
//   remainder : registered remainder, sign follows the dividend
//   exception : divide-by-zero flag, valid with ready and held afterwards
//   busy      : high from the accepted start edge until ready rises
//   ready     : one-cycle result-valid pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | 32 shift-subtract iterations on the magnitudes
// FIX   | apply quotient/remainder signs, force zero results on divide by 0
// DONE  | load output registers and pulse ready on the exit edge
module signed_div_seq
   import signed_div_seq_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_en,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             exception,
   output logic             busy,
   output logic             ready
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_iter;
   logic             w_fix;
   logic             w_done;

   // r_q starts as the dividend magnitude and shifts into the quotient.
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_pr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_dz;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_sub;

   // Magnitudes are kept unsigned, so 0x80000000 becomes 2^31 without loss.
   cond_negate u_neg_dividend (
      .i_en  (signed_en & dividend[WIDTH-1]),
      .i_val (dividend),
      .o_val (w_a_mag)
   );

   cond_negate u_neg_divisor (
      .i_en  (signed_en & divisor[WIDTH-1]),
      .i_val (divisor),
      .o_val (w_b_mag)
   );

   cond_negate u_neg_quotient (
      .i_en  (r_qneg),
      .i_val (r_q),
      .o_val (w_q_fix)
   );

   cond_negate u_neg_remainder (
      .i_en  (r_rneg),
      .i_val (r_pr[WIDTH-1:0]),
      .o_val (w_r_fix)
   );

   // Borrow out of the extra top bit decides whether the trial subtract stands.
   assign w_shift = {r_pr, r_q[WIDTH-1]};
   assign w_sub   = w_shift - {2'b00, r_b};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_iter      = 1'b0;
      w_fix       = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_iter = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = FIX;
            end
         end
         FIX: begin
            w_fix       = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q       <= '0;
         r_b       <= '0;
         r_pr      <= '0;
         r_cnt     <= '0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_dz      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         exception <= 1'b0;
         busy      <= 1'b0;
         ready     <= 1'b0;
      end else begin
         ready <= 1'b0;

         if (w_accept) begin
            r_q    <= w_a_mag;
            r_b    <= w_b_mag;
            r_pr   <= '0;
            r_cnt  <= '0;
            r_qneg <= signed_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rneg <= signed_en & dividend[WIDTH-1];
            r_dz   <= (divisor == '0);
            busy   <= 1'b1;
         end

         if (w_iter) begin
            if (!w_sub[WIDTH+1]) begin
               r_pr <= w_sub[WIDTH:0];
               r_q  <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
               r_pr <= w_shift[WIDTH:0];
               r_q  <= {r_q[WIDTH-2:0], 1'b0};
            end
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         end

         if (w_fix) begin
            r_q  <= r_dz ? '0 : w_q_fix;
            r_pr <= r_dz ? '0 : {1'b0, w_r_fix};
         end

         if (w_done) begin
            quotient  <= r_q;
            remainder <= r_pr[WIDTH-1:0];
            exception <= r_dz;
            busy      <= 1'b0;
            ready     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq: behavioural edge-count model with a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_signed_div_seq;

   localparam int LAT = 34;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b0;
   logic        start     = 1'b0;
   logic        signed_en = 1'b0;
   logic [31:0] dividend  = '0;
   logic [31:0] divisor   = '0;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        exception;
   logic        busy;
   logic        ready;

   int   n_checks = 0;
   int   n_errors = 0;
   logic cmp_on   = 1'b0;

   // Reference model state: edges since the accepted start, -1 when idle.
   int          m_edge  = -1;
   logic [64:0] m_pend  = '0;
   logic [31:0] m_q     = '0;
   logic [31:0] m_r     = '0;
   logic        m_e     = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_ready = 1'b0;

   always #5 clock = ~clock;

   signed_div_seq dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .signed_en (signed_en),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .exception (exception),
      .busy      (busy),
      .ready     (ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {quotient, remainder, exception} from plain 64-bit arithmetic.
   function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return {32'd0, 32'd0, 1'b1};
      if (s) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {q[31:0], r[31:0], 1'b0};
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'd0;
         1:       v = 32'hFFFF_FFFF;
         2:       v = 32'h8000_0000;
         3:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_edge  = -1;
         m_q     = '0;
         m_r     = '0;
         m_e     = 1'b0;
         m_busy  = 1'b0;
         m_ready = 1'b0;
      end else begin
         m_ready = 1'b0;
         if (m_edge >= 0) begin
            m_edge++;
            if (m_edge == LAT) begin
               {m_q, m_r, m_e} = m_pend;
               m_ready = 1'b1;
               m_busy  = 1'b0;
               m_edge  = -1;
            end
         end else if (start) begin
            m_pend = ref_div(dividend, divisor, signed_en);
            m_edge = 0;
            m_busy = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_on) begin
         chk("cmp_quotient", quotient, m_q);
         chk("cmp_remainder", remainder, m_r);
         chk("cmp_exception", 32'(exception), 32'(m_e));
         chk("cmp_busy", 32'(busy), 32'(m_busy));
         chk("cmp_ready", 32'(ready), 32'(m_ready));
      end
   end

   task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs, input logic sen);
      start     = 1'b1;
      dividend  = dvd;
      divisor   = dvs;
      signed_en = sen;
   endtask

   // Waits for edge 0, scrambles inputs while busy, optionally raises one
   // extra start sampled at edge extra_edge, then checks the result.
   task automatic run_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic ee, input int extra_edge);
      int          n    = 0;
      int          gaps = 0;
      logic        seen = 1'b0;
      logic [31:0] q_s  = '0;
      logic [31:0] r_s  = '0;
      logic        e_s  = 1'b0;
      @(posedge clock);
      while (n < 100 && !seen) begin
         @(negedge clock);
         start = (n + 1 == extra_edge);
         if (start) begin
            dividend  = 32'd9;
            divisor   = 32'd3;
            signed_en = 1'b0;
         end else begin
            dividend  = $urandom;
            divisor   = $urandom;
            signed_en = 1'($urandom);
         end
         @(posedge clock);
         n++;
         #1;
         if (ready) begin
            seen = 1'b1;
            q_s  = quotient;
            r_s  = remainder;
            e_s  = exception;
         end else if (!busy) begin
            gaps++;
         end
      end
      @(negedge clock);
      start = 1'b0;
      chk({tag, "_latency"}, 32'(n), 32'(LAT));
      chk({tag, "_quotient"}, q_s, eq);
      chk({tag, "_remainder"}, r_s, er);
      chk({tag, "_exception"}, 32'(e_s), 32'(ee));
      chk({tag, "_busy_gaps"}, 32'(gaps), 32'd0);
   endtask

   task automatic do_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic sen, input logic [31:0] eq, input logic [31:0] er,
                        input logic ee, input int extra_edge);
      @(negedge clock);
      launch(dvd, dvs, sen);
      run_op(tag, eq, er, ee, extra_edge);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cmp_on  = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_quotient", quotient, 32'd0);
      chk("reset_remainder", remainder, 32'd0);
      chk("reset_exception", 32'(exception), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);

      do_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0);
      do_op("sneg100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
      do_op("s100_neg7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);
      do_op("dz55", 32'd55, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      do_op("after_dz", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 0);
      do_op("s_min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 0);
      do_op("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 0);
      do_op("restart5", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 5);

      // Start held in the DONE cycle only: must be ignored.
      do_op("done_start", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT);
      @(posedge clock);
      #1;
      chk("done_start_busy", 32'(busy), 32'd0);
      chk("done_start_hold", quotient, 32'd14);

      // Start in the ready cycle is accepted immediately.
      do_op("b2b_first", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 0);
      launch(32'd9, 32'd3, 1'b0);
      run_op("b2b_second", 32'd3, 32'd0, 1'b0, 0);

      // Abort mid-run with asynchronous reset.
      @(negedge clock);
      launch(32'd100, 32'd7, 1'b0);
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_quotient", quotient, 32'd0);
      chk("abort_remainder", remainder, 32'd0);
      chk("abort_exception", 32'(exception), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clock);
      #2;
      reset_n = 1'b1;
      launch(32'd20, 32'd6, 1'b0);
      run_op("after_abort", 32'd3, 32'd2, 1'b0, 0);

      repeat (3000) begin
         @(negedge clock);
         start     = ($urandom_range(0, 5) == 0);
         signed_en = 1'($urandom);
         dividend  = pick();
         divisor   = pick();
         if ($urandom_range(0, 599) == 0) begin
            #2;
            reset_n = 1'b0;
            @(negedge clock);
            #2;
            reset_n = 1'b1;
         end
      end
      @(negedge clock);
      start = 1'b0;
      repeat (40) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
